sdram_frame_arbiter: RTL and testbench
======================================

Name: sdram_frame_arbiter

Overview:
- Shares the single full-page SDRAM controller between two streaming requesters: camera write FIFO (SDRAM write) and display read FIFO (SDRAM read).
- Decides when to start each 512-word burst, generates the row/bank burst address for each burst of a frame buffer, and steers burst data between FIFOs and controller.
- Sits between the FIFOs and the SDRAM controller, in the controller's clock domain.

Parameters:
- BURST_LEN, 512, words per controller burst; also the eligibility threshold.
- FRAME_BURSTS, 600, bursts per frame (640x480 16-bit words / 512).
- FRAME_BASE, 0, 15-bit {row,bank} burst address of burst 0.
- LVL_W, 11, width of FIFO level/space inputs.

Ports:
- clk  in  1  controller clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  allow new bursts to start.
- wr_frame_start  in  1  one-cycle pulse: camera frame start.
- rd_frame_start  in  1  one-cycle pulse: display frame start.
- wr_fifo_level  in  LVL_W  words available in write FIFO.
- wr_fifo_data  in  16  write FIFO head word (first-word-fall-through).
- wr_fifo_rd_en  out  1  pop write FIFO.
- rd_fifo_space  in  LVL_W  free words in read FIFO.
- rd_fifo_data  out  16  word to read FIFO.
- rd_fifo_wr_en  out  1  push read FIFO.
- ctrl_ready  in  1  controller idle and able to accept a request.
- ctrl_rw_en  out  1  request strobe to controller.
- ctrl_rw  out  1  1 = read, 0 = write.
- ctrl_addr  out  15  {row[12:0], bank[1:0]}.
- ctrl_wdata  out  16  write data to controller.
- ctrl_wdata_req  in  1  controller consumes ctrl_wdata this cycle.
- ctrl_rdata  in  16  read data from controller.
- ctrl_rdata_valid  in  1  ctrl_rdata valid this cycle.
- grant  out  2  one-hot current owner: [0] = write, [1] = read.
- xfer_err  out  1  sticky: a burst ended with beat count != BURST_LEN.

Behaviour:
- Reset values: all outputs 0, state IDLE, both burst indices 0, last_grant = read, frame-sync pending flags clear.
- Eligibility, evaluated in IDLE only:
  - write eligible when wr_fifo_level >= BURST_LEN.
  - read eligible when rd_fifo_space >= BURST_LEN.
- FSM states: IDLE, ISSUE, XFER.
- IDLE:
  - If enable && ctrl_ready && any requester eligible: select owner, register ctrl_rw / ctrl_addr / grant, set ctrl_rw_en = 1, go to ISSUE.
  - If both are eligible, the owner is the opposite of last_grant (round-robin).
- ISSUE:
  - ctrl_rw_en, ctrl_rw and ctrl_addr held stable.
  - The request is accepted in the cycle where ctrl_rw_en && ctrl_ready. On acceptance, clear ctrl_rw_en, clear the beat counter, go to XFER.
  - Otherwise stay in ISSUE (controller is busy with an auto-refresh) holding the request.
- XFER:
  - Write owner: ctrl_wdata = wr_fifo_data and wr_fifo_rd_en = ctrl_wdata_req, both combinational, zero latency.
  - Read owner: rd_fifo_data = ctrl_rdata and rd_fifo_wr_en = ctrl_rdata_valid, both combinational.
  - Each strobe from the controller increments a 10-bit beat counter.
  - Exit XFER on the first cycle with ctrl_ready == 1. On exit:
    - set xfer_err if beat count != BURST_LEN;
    - update last_grant and advance the owner's burst index;
    - clear grant; go to IDLE.
  - The next burst can start in the IDLE cycle immediately following.
- Non-owner strobes are ignored; wr_fifo_rd_en and rd_fifo_wr_en are never asserted for the non-owner.
- Address generation: ctrl_addr = FRAME_BASE + burst_index, 15-bit modulo add. burst_index counts 0..FRAME_BURSTS-1 and wraps to 0.
- Frame sync:
  - A frame_start pulse sets that port's pending flag.
  - The next burst issued for that port uses index 0 and clears the flag.
  - A pulse during that port's own XFER stays pending and applies to the following burst; the in-flight burst is not aborted.
  - A pulse coinciding with a wrap gives index 0 (same result).
- enable deasserted: an in-flight ISSUE or XFER completes normally; no new burst starts.
- Reset mid-burst: immediate return to reset values. The controller is reset by the same rst_n.

Decomposition:
- Package sdram_arb_pkg holds:
  - state encoding (IDLE, ISSUE, XFER);
  - RW_READ = 1'b1 and RW_WRITE = 1'b0;
  - GRANT_WR and GRANT_RD one-hot constants;
  - address width 15 and data width 16.
- Sub-module sdram_frame_addr_gen: per-port burst-index counter with pending frame-sync, wrap at FRAME_BURSTS, and base add. Instantiated twice (write, read).

Test Plan:
- Write only: wr_fifo_level = 600, rd_fifo_space = 0 -> one ISSUE with ctrl_rw = 0, ctrl_addr = FRAME_BASE; exactly 512 wr_fifo_rd_en pulses; xfer_err = 0; next write burst has ctrl_addr = FRAME_BASE + 1.
- Both eligible continuously -> grants alternate read, write, read, write (last_grant reset = read); read bursts produce 512 rd_fifo_wr_en pulses with data equal to the controller model's.
- Controller model holds ctrl_ready low for 10 cycles after the ISSUE entry (refresh) -> ctrl_rw_en stays high with a stable address; accepted only when ctrl_ready = 1; exactly one burst occurs.
- 600 write bursts -> burst 599 at FRAME_BASE + 599, burst 600 at FRAME_BASE. A wr_frame_start during write burst 5 -> burst 6 uses FRAME_BASE; read index unaffected.
- Controller model delivers 511 wdata_req strobes -> xfer_err = 1 after the burst and stays set until reset.
- rst_n asserted mid-XFER -> all outputs 0 asynchronously; after release, the first burst uses FRAME_BASE.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM frame arbiter: FSM states, request
// direction, one-hot grant codes and the controller bus widths.
package sdram_arb_pkg;

    localparam int ADDR_W = 15;  // {row[12:0], bank[1:0]}
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [1:0] GRANT_WR = 2'b01;
    localparam logic [1:0] GRANT_RD = 2'b10;

endpackage

// File: rtl/sdram_frame_addr_gen.sv
// Per-port burst address generator. Keeps the burst index within the frame
// buffer, restarts at burst 0 after a frame-start pulse, and adds the base.
module sdram_frame_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int                 FRAME_BURSTS = 600,
    parameter logic [ADDR_W-1:0]  FRAME_BASE   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,  // sets the pending restart
    input  logic              issue,        // a burst for this port is being issued
    input  logic              done,         // that burst has finished
    output logic [ADDR_W-1:0] addr
);

    localparam int IDX_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_eff;
    logic             pending;

    // A pending frame start overrides the running index for the next issue.
    assign idx_eff = pending ? '0 : idx;
    assign addr    = FRAME_BASE + ADDR_W'(idx_eff);

    // Index advance with wrap, and frame-start bookkeeping.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            if (done) begin
                idx <= (idx == IDX_W'(FRAME_BURSTS - 1)) ? '0 : idx + 1'b1;
            end else if (issue && pending) begin
                idx <= '0;
            end

            // A pulse arriving in the same cycle as an issue stays pending
            // for the following burst.
            if (frame_start) begin
                pending <= 1'b1;
            end else if (issue) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Shares one full-page SDRAM controller between the camera write FIFO and
// the display read FIFO, one fixed-length burst at a time, round-robin when
// both sides are ready.
module sdram_frame_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int                BURST_LEN    = 512,
    parameter int                FRAME_BURSTS = 600,
    parameter logic [ADDR_W-1:0] FRAME_BASE   = '0,
    parameter int                LVL_W        = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [DATA_W-1:0] wr_fifo_data,
    output logic              wr_fifo_rd_en,
    input  logic [LVL_W-1:0]  rd_fifo_space,
    output logic [DATA_W-1:0] rd_fifo_data,
    output logic              rd_fifo_wr_en,
    input  logic              ctrl_ready,
    output logic              ctrl_rw_en,
    output logic              ctrl_rw,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    input  logic              ctrl_wdata_req,
    input  logic [DATA_W-1:0] ctrl_rdata,
    input  logic              ctrl_rdata_valid,
    output logic [1:0]        grant,
    output logic              xfer_err
);

    localparam int BEAT_W = 10;

    state_t            state, state_d;
    logic              rw_en_d, rw_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        grant_d;
    logic [BEAT_W-1:0] beat_cnt, beat_d;
    logic              last_grant_rd, last_rd_d;

    logic              wr_elig, rd_elig, pick_rd;
    logic              wr_issue, rd_issue, wr_done, rd_done;
    logic              xfer_wr, xfer_rd, beat_strobe;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    sdram_frame_addr_gen #(
        .FRAME_BURSTS (FRAME_BURSTS),
        .FRAME_BASE   (FRAME_BASE)
    ) u_wr_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (wr_frame_start),
        .issue       (wr_issue),
        .done        (wr_done),
        .addr        (wr_addr)
    );

    sdram_frame_addr_gen #(
        .FRAME_BURSTS (FRAME_BURSTS),
        .FRAME_BASE   (FRAME_BASE)
    ) u_rd_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (rd_frame_start),
        .issue       (rd_issue),
        .done        (rd_done),
        .addr        (rd_addr)
    );

    assign wr_elig = (wr_fifo_level >= LVL_W'(BURST_LEN));
    assign rd_elig = (rd_fifo_space >= LVL_W'(BURST_LEN));
    // Read wins when it is the only candidate or when write went last.
    assign pick_rd = rd_elig && (!wr_elig || !last_grant_rd);

    // Data steering is combinational and gated to the current owner only.
    assign xfer_wr       = (state == ST_XFER) && (grant == GRANT_WR);
    assign xfer_rd       = (state == ST_XFER) && (grant == GRANT_RD);
    assign wr_fifo_rd_en = xfer_wr && ctrl_wdata_req;
    assign ctrl_wdata    = xfer_wr ? wr_fifo_data : '0;
    assign rd_fifo_wr_en = xfer_rd && ctrl_rdata_valid;
    assign rd_fifo_data  = xfer_rd ? ctrl_rdata : '0;
    assign beat_strobe   = wr_fifo_rd_en || rd_fifo_wr_en;

    // Next-state and next-output decode for the burst sequencer.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state;
        rw_en_d   = ctrl_rw_en;
        rw_d      = ctrl_rw;
        addr_d    = ctrl_addr;
        grant_d   = grant;
        beat_d    = beat_cnt;
        last_rd_d = last_grant_rd;
        err_d     = xfer_err;
        wr_issue  = 1'b0;
        rd_issue  = 1'b0;
        wr_done   = 1'b0;
        rd_done   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable && ctrl_ready && (wr_elig || rd_elig)) begin
                    state_d  = ST_ISSUE;
                    rw_en_d  = 1'b1;
                    rw_d     = pick_rd ? RW_READ : RW_WRITE;
                    addr_d   = pick_rd ? rd_addr : wr_addr;
                    grant_d  = pick_rd ? GRANT_RD : GRANT_WR;
                    rd_issue = pick_rd;
                    wr_issue = !pick_rd;
                end
            end

            ST_ISSUE: begin
                // Request stays on the bus until the controller is free.
                if (ctrl_ready) begin
                    rw_en_d = 1'b0;
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                beat_d = beat_cnt + BEAT_W'(beat_strobe);
                if (ctrl_ready) begin
                    if (beat_d != BEAT_W'(BURST_LEN)) begin
                        err_d = 1'b1;
                    end
                    if (grant == GRANT_RD) begin
                        rd_done   = 1'b1;
                        last_rd_d = 1'b1;
                    end else begin
                        wr_done   = 1'b1;
                        last_rd_d = 1'b0;
                    end
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered controller-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ctrl_rw_en    <= 1'b0;
            ctrl_rw       <= 1'b0;
            ctrl_addr     <= '0;
            grant         <= '0;
            beat_cnt      <= '0;
            last_grant_rd <= 1'b1;
            xfer_err      <= 1'b0;
        end else begin
            state         <= state_d;
            ctrl_rw_en    <= rw_en_d;
            ctrl_rw       <= rw_d;
            ctrl_addr     <= addr_d;
            grant         <= grant_d;
            beat_cnt      <= beat_d;
            last_grant_rd <= last_rd_d;
            xfer_err      <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter. The bench plays the SDRAM
// controller and both FIFOs; expected addresses/owners are worked out by hand.
module tb_sdram_frame_arbiter;

    localparam logic [1:0] G_WR = 2'b01;
    localparam logic [1:0] G_RD = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_frame_start = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic [10:0] wr_fifo_level = '0;
    logic [15:0] wr_fifo_data = '0;
    logic        wr_fifo_rd_en;
    logic [10:0] rd_fifo_space = '0;
    logic [15:0] rd_fifo_data;
    logic        rd_fifo_wr_en;
    logic        ctrl_ready = 1'b1;
    logic        ctrl_rw_en;
    logic        ctrl_rw;
    logic [14:0] ctrl_addr;
    logic [15:0] ctrl_wdata;
    logic        ctrl_wdata_req = 1'b0;
    logic [15:0] ctrl_rdata = '0;
    logic        ctrl_rdata_valid = 1'b0;
    logic [1:0]  grant;
    logic        xfer_err;

    int n_checks = 0;
    int n_errors = 0;

    sdram_frame_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .wr_frame_start   (wr_frame_start),
        .rd_frame_start   (rd_frame_start),
        .wr_fifo_level    (wr_fifo_level),
        .wr_fifo_data     (wr_fifo_data),
        .wr_fifo_rd_en    (wr_fifo_rd_en),
        .rd_fifo_space    (rd_fifo_space),
        .rd_fifo_data     (rd_fifo_data),
        .rd_fifo_wr_en    (rd_fifo_wr_en),
        .ctrl_ready       (ctrl_ready),
        .ctrl_rw_en       (ctrl_rw_en),
        .ctrl_rw          (ctrl_rw),
        .ctrl_addr        (ctrl_addr),
        .ctrl_wdata       (ctrl_wdata),
        .ctrl_wdata_req   (ctrl_wdata_req),
        .ctrl_rdata       (ctrl_rdata),
        .ctrl_rdata_valid (ctrl_rdata_valid),
        .grant            (grant),
        .xfer_err         (xfer_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One burst as seen from the controller side. Called at a falling edge.
    // busy: cycles the controller keeps ready low after seeing the request.
    // pulse_beat: beat index at which a camera frame start is pulsed (-1 none).
    // drop_en: deassert enable once the request is seen.
    task automatic do_burst(input logic rw, input logic [14:0] exp_addr, input int beats,
                            input int busy, input int pulse_beat, input logic drop_en);
        logic seen;
        int   own, other, bad;
        seen  = ctrl_rw_en;
        own   = 0;
        other = 0;
        bad   = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = ctrl_rw_en;
        end
        if (!seen) begin
            check("issue_timeout", 32'd0, 32'd1);
            return;
        end
        if (drop_en) enable = 1'b0;
        check("rw", ctrl_rw, rw);
        check("addr", ctrl_addr, exp_addr);
        check("grant", grant, rw ? G_RD : G_WR);
        if (busy > 0) begin
            ctrl_ready = 1'b0;
            repeat (busy) begin
                @(negedge clk);
                check("hold_en", ctrl_rw_en, 1);
                check("hold_addr", ctrl_addr, exp_addr);
            end
            ctrl_ready = 1'b1;
        end
        @(negedge clk);
        check("accept", ctrl_rw_en, 0);
        ctrl_ready = 1'b0;
        for (int i = 0; i < beats; i++) begin
            wr_fifo_data = 16'h5000 + 16'(i);
            ctrl_rdata   = 16'hC000 ^ 16'(i);
            if (rw) begin
                ctrl_rdata_valid = 1'b1;
                ctrl_wdata_req   = i[0];
            end else begin
                ctrl_wdata_req   = 1'b1;
                ctrl_rdata_valid = i[0];
            end
            if (i == pulse_beat) wr_frame_start = 1'b1;
            #1;
            if (rw) begin
                own   += int'(rd_fifo_wr_en);
                other += int'(wr_fifo_rd_en);
                if (rd_fifo_data !== (16'hC000 ^ 16'(i))) bad++;
            end else begin
                own   += int'(wr_fifo_rd_en);
                other += int'(rd_fifo_wr_en);
                if (ctrl_wdata !== (16'h5000 + 16'(i))) bad++;
            end
            @(negedge clk);
            wr_frame_start = 1'b0;
        end
        ctrl_wdata_req   = 1'b0;
        ctrl_rdata_valid = 1'b0;
        ctrl_ready       = 1'b1;
        @(negedge clk);
        check("pulses", own, beats);
        check("nonowner", other, 0);
        check("data", bad, 0);
        check("grant_clr", grant, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int busy_issues;
        // Reset state
        #12;
        check("rst_grant", grant, 0);
        check("rst_rw_en", ctrl_rw_en, 0);
        check("rst_addr", ctrl_addr, 0);
        check("rst_err", xfer_err, 0);
        check("rst_wr_rd_en", wr_fifo_rd_en, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // No burst while disabled even though the write side is eligible
        wr_fifo_level = 11'd600;
        repeat (5) @(negedge clk);
        check("disabled_idle", ctrl_rw_en, 0);

        // Write only: two consecutive bursts at base, base+1
        enable = 1'b1;
        do_burst(1'b0, 15'd0, 512, 0, -1, 1'b0);
        check("err_after_w0", xfer_err, 0);
        do_burst(1'b0, 15'd1, 512, 0, -1, 1'b0);

        // Both eligible: write went last, so read, write, read, write
        rd_fifo_space = 11'd600;
        do_burst(1'b1, 15'd0, 512, 0, -1, 1'b0);
        do_burst(1'b0, 15'd2, 512, 0, -1, 1'b0);
        do_burst(1'b1, 15'd1, 512, 0, -1, 1'b0);
        do_burst(1'b0, 15'd3, 512, 0, -1, 1'b0);

        // Refresh stall: request held 10 cycles, enable dropped in flight
        rd_fifo_space = 11'd0;
        do_burst(1'b0, 15'd4, 512, 10, -1, 1'b1);
        busy_issues = 0;
        repeat (10) begin
            @(negedge clk);
            busy_issues += int'(ctrl_rw_en);
        end
        check("one_burst_only", busy_issues, 0);
        enable = 1'b1;

        // Frame start during write burst 5 restarts at base; read index untouched
        do_burst(1'b0, 15'd5, 512, 0, 3, 1'b0);
        do_burst(1'b0, 15'd0, 512, 0, -1, 1'b0);
        rd_fifo_space = 11'd600;
        do_burst(1'b1, 15'd2, 512, 0, -1, 1'b0);
        rd_fifo_space = 11'd0;
        do_burst(1'b0, 15'd1, 512, 0, -1, 1'b0);
        check("err_before_short", xfer_err, 0);

        // Short burst sets the sticky error
        do_burst(1'b0, 15'd2, 511, 0, -1, 1'b0);
        check("err_short", xfer_err, 1);

        // Run the write index to the end of the frame and across the wrap
        for (int k = 3; k < 600; k++) begin
            do_burst(1'b0, 15'(k), 0, 0, -1, 1'b0);
        end
        do_burst(1'b0, 15'd0, 0, 0, -1, 1'b0);
        check("err_sticky", xfer_err, 1);

        // Reset in the middle of a write transfer
        begin
            logic seen;
            seen = ctrl_rw_en;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = ctrl_rw_en;
            end
            check("pre_reset_issue", seen, 1);
            check("pre_reset_addr", ctrl_addr, 15'd1);
        end
        @(negedge clk);
        ctrl_ready     = 1'b0;
        ctrl_wdata_req = 1'b1;
        wr_fifo_data   = 16'h1234;
        repeat (3) @(negedge clk);
        check("mid_xfer_rd_en", wr_fifo_rd_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant", grant, 0);
        check("async_wr_rd_en", wr_fifo_rd_en, 0);
        check("async_wdata", ctrl_wdata, 0);
        check("async_err", xfer_err, 0);
        check("async_addr", ctrl_addr, 0);
        ctrl_wdata_req = 1'b0;
        ctrl_ready     = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        do_burst(1'b0, 15'd0, 512, 0, -1, 1'b0);
        check("err_after_reset", xfer_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
